alu_sequencer: RTL and testbench

- Multi-cycle issue/sequencing controller in front of the combinational ALU.
- Accepts one operation at a time from the execution unit over a valid/ready handshake and drives the ALU from latched operands.
- Holds the result for the ALU's base cost plus the ALU's dynamic shift/rotate cost (alu_cycles), then returns result and flags over a second valid/ready handshake.
- Owns the architectural PSW flags register that feeds the ALU's flags_in and commits ALU flags when the response is accepted.

---
 rtl/alu_sequencer.sv | 169 ++++++++++++++++
 tb/tb_alu_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Issue/sequencing controller in front of the combinational ALU: latches one operation,
// holds the ALU for base + dynamic cycles, returns result/flags and owns the PSW flags.
package alu_sequencer_pkg;
    typedef enum logic [3:0] {
        ALU_OP_ADD  = 4'd0,
        ALU_OP_ADDC = 4'd1,
        ALU_OP_SUB  = 4'd2,
        ALU_OP_SUBC = 4'd3,
        ALU_OP_AND  = 4'd4,
        ALU_OP_OR   = 4'd5,
        ALU_OP_XOR  = 4'd6,
        ALU_OP_ROL  = 4'd7,
        ALU_OP_ROR  = 4'd8,
        ALU_OP_SHL  = 4'd9,
        ALU_OP_SHR  = 4'd10,
        ALU_OP_MUL  = 4'd11,
        ALU_OP_MULU = 4'd12
    } alu_operation_e;

    typedef struct packed {
        logic s;
        logic z;
        logic v;
        logic cy;
    } flags_t;
endpackage

// state | meaning
// IDLE  | ready for a request
// EXEC  | ALU driven from latches; result and cycle count captured
// WAIT  | counting down the extra cycles
// DONE  | response held until accepted, then flags commit
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter flags_t FLAGS_RESET = '0,
    parameter int     CNT_W       = 7
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           req_valid,
    output logic           req_ready,
    input  alu_operation_e req_op,
    input  logic [15:0]    req_ta,
    input  logic [15:0]    req_tb,
    input  logic           req_wide,
    input  logic [3:0]     req_base_cycles,
    output logic           resp_valid,
    input  logic           resp_ready,
    output logic [31:0]    resp_result,
    output flags_t         resp_flags,
    input  logic           flush,
    input  logic           flags_wr,
    input  flags_t         flags_wdata,
    output flags_t         flags_q,
    output alu_operation_e alu_operation,
    output logic [15:0]    alu_ta,
    output logic [15:0]    alu_tb,
    output logic           alu_wide,
    output flags_t         alu_flags_in,
    input  logic [31:0]    alu_result,
    input  logic [5:0]     alu_cycles_in,
    input  flags_t         alu_flags
);

    typedef enum logic [1:0] {IDLE, EXEC, WAIT, DONE} state_e;

    state_e             r_state;
    alu_operation_e     r_op;
    logic [15:0]        r_ta;
    logic [15:0]        r_tb;
    logic               r_wide;
    logic [3:0]         r_base;
    flags_t             r_flags_in;
    logic [CNT_W-1:0]   r_count;
    logic               r_resp_valid;
    logic [31:0]        r_resp_result;
    flags_t             r_resp_flags;
    flags_t             r_flags_q;
    logic [CNT_W-1:0]   w_n;

    assign w_n = CNT_W'(r_base) + CNT_W'(alu_cycles_in);

    assign req_ready     = (r_state == IDLE);
    assign resp_valid    = r_resp_valid;
    assign resp_result   = r_resp_result;
    assign resp_flags    = r_resp_flags;
    assign flags_q       = r_flags_q;
    assign alu_operation = r_op;
    assign alu_ta        = r_ta;
    assign alu_tb        = r_tb;
    assign alu_wide      = r_wide;
    assign alu_flags_in  = r_flags_in;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_op          <= ALU_OP_ADD;
            r_ta          <= '0;
            r_tb          <= '0;
            r_wide        <= 1'b0;
            r_base        <= '0;
            r_flags_in    <= FLAGS_RESET;
            r_count       <= '0;
            r_resp_valid  <= 1'b0;
            r_resp_result <= '0;
            r_resp_flags  <= FLAGS_RESET;
            r_flags_q     <= FLAGS_RESET;
        end else begin
            // A direct write beats the response commit; flush suppresses the commit.
            if (flags_wr)
                r_flags_q <= flags_wdata;
            else if (r_state == DONE && resp_ready && !flush)
                r_flags_q <= r_resp_flags;

            if (flush && r_state != IDLE) begin
                r_state      <= IDLE;
                r_resp_valid <= 1'b0;
                r_count      <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (req_valid && !flush) begin
                            r_op       <= req_op;
                            r_ta       <= req_ta;
                            r_tb       <= req_tb;
                            r_wide     <= req_wide;
                            r_base     <= req_base_cycles;
                            r_flags_in <= r_flags_q;
                            r_state    <= EXEC;
                        end
                    end
                    EXEC: begin
                        r_resp_result <= alu_result;
                        r_resp_flags  <= alu_flags;
                        if (w_n == '0) begin
                            r_state      <= DONE;
                            r_resp_valid <= 1'b1;
                        end else begin
                            r_count <= w_n;
                            r_state <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (r_count != '0)
                            r_count <= r_count - 1'b1;
                        if (r_count == CNT_W'(1)) begin
                            r_state      <= DONE;
                            r_resp_valid <= 1'b1;
                        end
                    end
                    DONE: begin
                        if (resp_ready) begin
                            r_state      <= IDLE;
                            r_resp_valid <= 1'b0;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && r_state == WAIT)
            assert (r_count != '0);
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a small behavioural ALU on the ALU-side ports.
module tb_alu_sequencer;
    import alu_sequencer_pkg::*;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           req_valid;
    logic           req_ready;
    alu_operation_e req_op;
    logic [15:0]    req_ta;
    logic [15:0]    req_tb;
    logic           req_wide;
    logic [3:0]     req_base_cycles;
    logic           resp_valid;
    logic           resp_ready;
    logic [31:0]    resp_result;
    flags_t         resp_flags;
    logic           flush;
    logic           flags_wr;
    flags_t         flags_wdata;
    flags_t         flags_q;
    alu_operation_e alu_operation;
    logic [15:0]    alu_ta;
    logic [15:0]    alu_tb;
    logic           alu_wide;
    flags_t         alu_flags_in;
    logic [31:0]    alu_result;
    logic [5:0]     alu_cycles_in;
    flags_t         alu_flags;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc;
    logic rr_seen;
    logic rv_seen;

    alu_sequencer dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_ta(req_ta), .req_tb(req_tb), .req_wide(req_wide),
        .req_base_cycles(req_base_cycles),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_result(resp_result), .resp_flags(resp_flags),
        .flush(flush), .flags_wr(flags_wr), .flags_wdata(flags_wdata), .flags_q(flags_q),
        .alu_operation(alu_operation), .alu_ta(alu_ta), .alu_tb(alu_tb),
        .alu_wide(alu_wide), .alu_flags_in(alu_flags_in),
        .alu_result(alu_result), .alu_cycles_in(alu_cycles_in), .alu_flags(alu_flags)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: only the operations this bench issues.
    logic [16:0] m_sum16;
    logic [8:0]  m_sum8;
    logic [7:0]  m_rot8;
    logic [15:0] m_rot16;
    logic        m_cin;
    always_comb begin
        alu_result    = '0;
        alu_cycles_in = '0;
        alu_flags     = '0;
        m_sum16       = '0;
        m_sum8        = '0;
        m_rot8        = alu_ta[7:0];
        m_rot16       = alu_ta;
        m_cin         = 1'b0;
        case (alu_operation)
            ALU_OP_ADD, ALU_OP_ADDC: begin
                m_cin = (alu_operation == ALU_OP_ADDC) ? alu_flags_in.cy : 1'b0;
                if (alu_wide) begin
                    m_sum16      = {1'b0, alu_ta} + {1'b0, alu_tb} + 17'(m_cin);
                    alu_result   = {16'b0, m_sum16[15:0]};
                    alu_flags.cy = m_sum16[16];
                    alu_flags.s  = m_sum16[15];
                    alu_flags.z  = (m_sum16[15:0] == 16'h0);
                    alu_flags.v  = (alu_ta[15] == alu_tb[15]) && (m_sum16[15] != alu_ta[15]);
                end else begin
                    m_sum8       = {1'b0, alu_ta[7:0]} + {1'b0, alu_tb[7:0]} + 9'(m_cin);
                    alu_result   = {24'b0, m_sum8[7:0]};
                    alu_flags.cy = m_sum8[8];
                    alu_flags.s  = m_sum8[7];
                    alu_flags.z  = (m_sum8[7:0] == 8'h0);
                    alu_flags.v  = (alu_ta[7] == alu_tb[7]) && (m_sum8[7] != alu_ta[7]);
                end
            end
            ALU_OP_ROL: begin
                for (int i = 0; i < 16; i++) begin
                    if (i < int'(alu_tb[3:0])) begin
                        m_rot8  = {m_rot8[6:0], m_rot8[7]};
                        m_rot16 = {m_rot16[14:0], m_rot16[15]};
                    end
                end
                alu_result    = alu_wide ? {16'b0, m_rot16} : {24'b0, m_rot8};
                alu_cycles_in = alu_tb[5:0];
                alu_flags.cy  = alu_result[0];
                alu_flags.s   = alu_wide ? alu_result[15] : alu_result[7];
                alu_flags.z   = (alu_result == 32'h0);
            end
            ALU_OP_MULU: begin
                alu_result  = {16'b0, alu_ta} * {16'b0, alu_tb};
                alu_flags.z = (alu_result == 32'h0);
            end
            default: ;
        endcase
    end

    function automatic flags_t mkf(input logic s, input logic z, input logic v, input logic cy);
        flags_t f;
        f.s = s; f.z = z; f.v = v; f.cy = cy;
        return f;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drive a request at a negedge; returns at the negedge of cycle T+1.
    task automatic issue(input alu_operation_e op, input logic [15:0] ta, input logic [15:0] tb,
                         input logic wide, input logic [3:0] base);
        req_op = op; req_ta = ta; req_tb = tb; req_wide = wide; req_base_cycles = base;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Counts cycles (relative to accept edge T) until resp_valid, bounded.
    task automatic wait_valid(input int start, output int c);
        c = start;
        rr_seen = 1'b0;
        while (resp_valid !== 1'b1 && c < 100) begin
            if (req_ready) rr_seen = 1'b1;
            @(negedge clk);
            c++;
        end
    endtask

    initial begin
        reset_n = 1'b0; req_valid = 1'b0; req_op = ALU_OP_ADD; req_ta = '0; req_tb = '0;
        req_wide = 1'b0; req_base_cycles = '0; resp_ready = 1'b1; flush = 1'b0;
        flags_wr = 1'b0; flags_wdata = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_result", resp_result, 32'h0);
        chk("rst_flags_q", 32'(flags_q), 32'h0);
        chk("rst_alu_op", 32'(alu_operation), 32'(ALU_OP_ADD));

        // ADD wide 0x7FFF + 1
        issue(ALU_OP_ADD, 16'h7FFF, 16'h0001, 1'b1, 4'd0);
        chk("add_exec_valid", 32'(resp_valid), 32'd0);
        chk("add_exec_ready", 32'(req_ready), 32'd0);
        wait_valid(1, cyc);
        chk("add_latency", 32'(cyc), 32'd2);
        chk("add_result", resp_result, 32'h0000_8000);
        chk("add_flags", 32'(resp_flags), 32'(mkf(1'b1, 1'b0, 1'b1, 1'b0)));
        @(negedge clk);
        chk("add_valid_1cyc", 32'(resp_valid), 32'd0);
        chk("add_flags_q", 32'(flags_q), 32'(mkf(1'b1, 1'b0, 1'b1, 1'b0)));
        chk("add_ready_back", 32'(req_ready), 32'd1);

        // ROL byte 0x81 by 3, base 2 -> N = 5
        issue(ALU_OP_ROL, 16'h0081, 16'h0003, 1'b0, 4'd2);
        wait_valid(1, cyc);
        chk("rol_latency", 32'(cyc), 32'd7);
        chk("rol_ready_low_wait", 32'(rr_seen), 32'd0);
        chk("rol_ready_low_done", 32'(req_ready), 32'd0);
        chk("rol_result", resp_result, 32'h0000_000C);
        @(negedge clk);
        chk("rol_flags_q", 32'(flags_q), 32'(mkf(1'b0, 1'b0, 1'b0, 1'b0)));

        // MULU wide 0x1234 * 0x0100, base 1
        issue(ALU_OP_MULU, 16'h1234, 16'h0100, 1'b1, 4'd1);
        wait_valid(1, cyc);
        chk("mulu_latency", 32'(cyc), 32'd3);
        chk("mulu_result", resp_result, 32'h0012_3400);
        chk("mulu_cy", 32'(resp_flags.cy), 32'd0);
        chk("mulu_v", 32'(resp_flags.v), 32'd0);
        @(negedge clk);

        // Backpressure: ADD byte 0x80 + 0x80, consumer stalls 4 cycles
        resp_ready = 1'b0;
        issue(ALU_OP_ADD, 16'h0080, 16'h0080, 1'b0, 4'd0);
        wait_valid(1, cyc);
        chk("bp_latency", 32'(cyc), 32'd2);
        for (int i = 0; i < 4; i++) begin
            chk("bp_result", resp_result, 32'h0000_0000);
            chk("bp_flags", 32'(resp_flags), 32'(mkf(1'b0, 1'b1, 1'b1, 1'b1)));
            chk("bp_flags_q", 32'(flags_q), 32'h0);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            chk("bp_valid", 32'(resp_valid), 32'd1);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        chk("bp_commit", 32'(flags_q), 32'(mkf(1'b0, 1'b1, 1'b1, 1'b1)));
        chk("bp_valid_drop", 32'(resp_valid), 32'd0);

        // Snapshot and write priority
        flags_wr = 1'b1; flags_wdata = mkf(1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        flags_wr = 1'b0;
        chk("wr_idle", 32'(flags_q), 32'(mkf(1'b0, 1'b0, 1'b0, 1'b1)));
        resp_ready = 1'b0;
        issue(ALU_OP_ADDC, 16'h00FF, 16'h0000, 1'b0, 4'd3);
        @(negedge clk);
        flags_wr = 1'b1; flags_wdata = mkf(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        flags_wr = 1'b0;
        chk("snap_cy_held", 32'(alu_flags_in.cy), 32'd1);
        chk("wr_wait", 32'(flags_q), 32'h0);
        wait_valid(3, cyc);
        chk("addc_latency", 32'(cyc), 32'd5);
        chk("addc_result", resp_result, 32'h0000_0000);
        chk("addc_flags", 32'(resp_flags), 32'(mkf(1'b0, 1'b1, 1'b0, 1'b1)));
        resp_ready = 1'b1; flags_wr = 1'b1; flags_wdata = mkf(1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        flags_wr = 1'b0;
        chk("wr_beats_commit", 32'(flags_q), 32'(mkf(1'b1, 1'b0, 1'b1, 1'b0)));
        chk("addc_valid_drop", 32'(resp_valid), 32'd0);

        // Flush during WAIT with counter = 3 (cycle T+4)
        issue(ALU_OP_ROL, 16'h0081, 16'h0003, 1'b0, 4'd2);
        repeat (3) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_ready", 32'(req_ready), 32'd1);
        chk("flush_valid", 32'(resp_valid), 32'd0);
        rv_seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (resp_valid) rv_seen = 1'b1;
        end
        chk("flush_no_resp", 32'(rv_seen), 32'd0);
        chk("flush_flags_q", 32'(flags_q), 32'(mkf(1'b1, 1'b0, 1'b1, 1'b0)));

        // Flush in IDLE drops a simultaneous request
        req_op = ALU_OP_ADD; req_ta = 16'h0001; req_tb = 16'h0001; req_wide = 1'b1;
        req_base_cycles = 4'd0; req_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        req_valid = 1'b0; flush = 1'b0;
        chk("idle_flush_drop", 32'(req_ready), 32'd1);
        repeat (3) @(negedge clk);
        chk("idle_flush_no_resp", 32'(resp_valid), 32'd0);

        // Flush beats resp_ready in DONE: no commit
        resp_ready = 1'b0;
        issue(ALU_OP_ADD, 16'h0080, 16'h0080, 1'b0, 4'd0);
        wait_valid(1, cyc);
        chk("dflush_latency", 32'(cyc), 32'd2);
        flush = 1'b1; resp_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("dflush_valid", 32'(resp_valid), 32'd0);
        chk("dflush_no_commit", 32'(flags_q), 32'(mkf(1'b1, 1'b0, 1'b1, 1'b0)));

        // Reset during WAIT
        issue(ALU_OP_ROL, 16'h0081, 16'h0003, 1'b0, 4'd2);
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("mrst_req_ready", 32'(req_ready), 32'd1);
        chk("mrst_resp_valid", 32'(resp_valid), 32'd0);
        chk("mrst_resp_result", resp_result, 32'h0);
        chk("mrst_resp_flags", 32'(resp_flags), 32'h0);
        chk("mrst_flags_q", 32'(flags_q), 32'h0);
        chk("mrst_alu_op", 32'(alu_operation), 32'(ALU_OP_ADD));
        chk("mrst_alu_ta", 32'(alu_ta), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
